// File: rtl/encoder_serial_tx.sv
// ---------------------------------------------------------------------------
// encoder_serial_tx
// Transmit end of the (14,4) systematic block-code link. Accepts a 4-bit data
// word on a valid/ready handshake, encodes it to a 14-bit codeword and shifts
// the codeword out one bit per cycle with frame strobes. The parallel codeword
// is also exposed for loopback into the syndrome decoder.
//
// Optional build macro: ERR_INJECT_EN
//   Adds err_en/err_pos inputs. When err_en=1 and err_pos<=13 at accept, the
//   latched codeword bit err_pos is inverted (for exercising decoder correction).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   din[3:0]     data word
//   din_valid    din is valid
//   din_ready    block can accept din this cycle
//   cw[13:0]     codeword of the frame in flight or last sent
//   sdo          serial codeword bit (IDLE_LEVEL when no frame is active)
//   sdo_valid    sdo carries a codeword bit
//   sof / eof    first / last bit of a frame
//   frames_sent  completed frame count, wraps modulo 2^CNT_W
//   err_en, err_pos[3:0]   (ERR_INJECT_EN only) single-bit error injection
// ---------------------------------------------------------------------------
module encoder_serial_tx #(
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       din,
  input  logic             din_valid,
`ifdef ERR_INJECT_EN
  input  logic             err_en,
  input  logic [3:0]       err_pos,
`endif
  output logic             din_ready,
  output logic [13:0]      cw,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sof,
  output logic             eof,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int unsigned CW_W     = 14;
  localparam logic [3:0]  LAST_BIT = 4'(CW_W - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic [CNT_W-1:0]  frames_q, frames_d;
  logic              sdo_q, sdo_d;
  logic              sdo_valid_q, sdo_valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              din_ready_q, din_ready_d;

  logic [CW_W-1:0]   enc_c;
  logic              accept_c;
  logic [3:0]        sel_c;

  // Systematic encoding: data in cw[13:10], parity p9..p0 in cw[9:0]
  always_comb begin
    enc_c = {din,
             din[0] ^ din[2] ^ din[3],
             din[2] ^ din[3],
             din[0] ^ din[1] ^ din[3],
             din[1] ^ din[3],
             din[0] ^ din[3],
             din[0] ^ din[1] ^ din[2],
             din[1] ^ din[2],
             din[0] ^ din[2],
             din[0] ^ din[1],
             din[0]};
`ifdef ERR_INJECT_EN
    // Positions 14/15 fall outside the codeword and are ignored
    if (err_en && (err_pos <= LAST_BIT)) begin
      enc_c = enc_c ^ (CW_W'(1) << err_pos);
    end
`endif
  end

  assign accept_c = din_valid & din_ready_q;

  // State register: FSM state, frame data, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cw_q        <= '0;
      frames_q    <= '0;
      sdo_q       <= IDLE_LEVEL;
      sdo_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      din_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cw_q        <= cw_d;
      frames_q    <= frames_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      din_ready_q <= din_ready_d;
    end
  end

  // Next-state logic; a word accepted on the eof cycle chains with no gap
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cw_d      = cw_q;
    frames_d  = frames_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          cw_d      = enc_c;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          frames_d  = frames_q + CNT_W'(1);
          bit_cnt_d = '0;
          if (accept_c) begin
            cw_d = enc_c;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: computed from next-state values so the registered outputs
  // show the first bit in the cycle right after the accepting edge
  always_comb begin
    sdo_d       = IDLE_LEVEL;
    sdo_valid_d = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    sel_c       = LSB_FIRST ? bit_cnt_d : (LAST_BIT - bit_cnt_d);
    din_ready_d = (state_d == IDLE) || (bit_cnt_d == LAST_BIT);
    if (state_d == SHIFT) begin
      sdo_valid_d = 1'b1;
      sdo_d       = cw_d[sel_c];
      sof_d       = (bit_cnt_d == 4'd0);
      eof_d       = (bit_cnt_d == LAST_BIT);
    end
  end

  assign din_ready   = din_ready_q;
  assign cw          = cw_q;
  assign sdo         = sdo_q;
  assign sdo_valid   = sdo_valid_q;
  assign sof         = sof_q;
  assign eof         = eof_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_encoder_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_encoder_serial_tx
// Directed bench for encoder_serial_tx. u_dut: LSB-first, idle low, 16-bit
// counter. u_msb: MSB-first, idle high, 2-bit counter (shows wrap). Both share
// all inputs. Error-injection steps are built only with ERR_INJECT_EN.
// ---------------------------------------------------------------------------
module tb_encoder_serial_tx;

  logic        clk;
  logic        reset;
  logic [3:0]  din;
  logic        din_valid;
`ifdef ERR_INJECT_EN
  logic        err_en;
  logic [3:0]  err_pos;
`endif

  logic        din_ready, sdo, sdo_valid, sof, eof;
  logic [13:0] cw;
  logic [15:0] frames_sent;

  logic        m_din_ready, m_sdo, m_sdo_valid, m_sof, m_eof;
  logic [13:0] m_cw;
  logic [1:0]  m_frames_sent;

  int n_pass  = 0;
  int n_total = 0;
  int exp_frames;

  encoder_serial_tx u_dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
`ifdef ERR_INJECT_EN
    .err_en      (err_en),
    .err_pos     (err_pos),
`endif
    .din_ready   (din_ready),
    .cw          (cw),
    .sdo         (sdo),
    .sdo_valid   (sdo_valid),
    .sof         (sof),
    .eof         (eof),
    .frames_sent (frames_sent)
  );

  encoder_serial_tx #(
    .LSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b1),
    .CNT_W      (2)
  ) u_msb (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
`ifdef ERR_INJECT_EN
    .err_en      (err_en),
    .err_pos     (err_pos),
`endif
    .din_ready   (m_din_ready),
    .cw          (m_cw),
    .sdo         (m_sdo),
    .sdo_valid   (m_sdo_valid),
    .sof         (m_sof),
    .eof         (m_eof),
    .frames_sent (m_frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Parity columns p9..p0, used only by the reference syndrome decoder
  function automatic logic [9:0] par(input logic [3:0] d);
    par = {d[0]^d[2]^d[3], d[2]^d[3], d[0]^d[1]^d[3], d[1]^d[3], d[0]^d[3],
           d[0]^d[1]^d[2], d[1]^d[2], d[0]^d[2], d[0]^d[1], d[0]};
  endfunction

  // Reference decoder: corrects a single data-bit error, ignores parity errors
  function automatic logic [3:0] decode(input logic [13:0] c);
    logic [9:0] syn;
    syn    = c[9:0] ^ par(c[13:10]);
    decode = c[13:10];
    for (int i = 0; i < 4; i++) begin
      if (syn == par(4'(1) << i)) decode[i] = ~decode[i];
    end
  endfunction

  // Called at the bit-0 sample point; returns at the sample point after bit 13
  task automatic run_frame(input string tag, input logic [13:0] ecw);
    for (int i = 0; i < 14; i++) begin
      check({tag, "_sdo"},   32'(sdo),         32'(ecw[i]));
      check({tag, "_msdo"},  32'(m_sdo),       32'(ecw[13-i]));
      check({tag, "_valid"}, 32'(sdo_valid),   32'(1));
      check({tag, "_sof"},   32'(sof),         32'(i == 0));
      check({tag, "_eof"},   32'(eof),         32'(i == 13));
      check({tag, "_rdy"},   32'(din_ready),   32'(i == 13));
      check({tag, "_mrdy"},  32'(m_din_ready), 32'(i == 13));
      @(negedge clk);
    end
  endtask

  logic [3:0]  t2_d  [3];
  logic [13:0] t2_cw [3];

  initial begin
    t2_d  = '{4'b0000, 4'b1111, 4'b0001};
    t2_cw = '{14'h0000, 14'h3E91, 14'h06B7};
    reset     = 1'b1;
    din       = 4'b0000;
    din_valid = 1'b0;
`ifdef ERR_INJECT_EN
    err_en    = 1'b0;
    err_pos   = 4'd0;
`endif
    exp_frames = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(din_ready),   32'(1));
    check("rst_valid",  32'(sdo_valid),   32'(0));
    check("rst_sdo",    32'(sdo),         32'(0));
    check("rst_msdo",   32'(m_sdo),       32'(1));
    check("rst_sof",    32'(sof),         32'(0));
    check("rst_eof",    32'(eof),         32'(0));
    check("rst_cw",     32'(cw),          32'(0));
    check("rst_frames", 32'(frames_sent), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_valid", 32'(sdo_valid), 32'(0));
    check("idle_ready", 32'(din_ready), 32'(1));

    // Single frame 1011, valid pulsed for one cycle
    din = 4'b1011; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("t1_cw",  32'(cw),         32'(14'h2D8D));
    check("t1_mcw", 32'(m_cw),       32'(14'h2D8D));
    check("t1_dec", 32'(decode(cw)), 32'(4'b1011));
    run_frame("t1", 14'h2D8D);
    exp_frames++;
    check("t1_frames",  32'(frames_sent),   32'(exp_frames));
    check("t1_mframes", 32'(m_frames_sent), 32'(exp_frames % 4));
    check("t1_after_valid", 32'(sdo_valid), 32'(0));
    check("t1_after_sdo",   32'(sdo),       32'(0));
    check("t1_after_msdo",  32'(m_sdo),     32'(1));
    check("t1_cw_hold",     32'(cw),        32'(14'h2D8D));
    repeat (3) @(negedge clk);
    check("t1_cw_hold2",    32'(cw),        32'(14'h2D8D));

    // Encoder vectors with decoder loopback
    for (int k = 0; k < 3; k++) begin
      din = t2_d[k]; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      check("t2_cw",  32'(cw),         32'(t2_cw[k]));
      check("t2_dec", 32'(decode(cw)), 32'(t2_d[k]));
      run_frame("t2", t2_cw[k]);
      exp_frames++;
    end
    check("t2_frames", 32'(frames_sent), 32'(exp_frames));

    // Back-to-back: second word accepted on the eof cycle
    din = 4'b0001; din_valid = 1'b1;
    @(negedge clk);
    din = 4'b1111;
    check("t3_cw1", 32'(cw), 32'(14'h06B7));
    run_frame("t3a", 14'h06B7);
    din_valid = 1'b0;
    exp_frames++;
    check("t3_cw2",     32'(cw),          32'(14'h3E91));
    check("t3_frames1", 32'(frames_sent), 32'(exp_frames));
    run_frame("t3b", 14'h3E91);
    exp_frames++;
    check("t3_frames2",  32'(frames_sent),   32'(exp_frames));
    check("t3_mframes",  32'(m_frames_sent), 32'(exp_frames % 4));
    check("t3_idle",     32'(sdo_valid),     32'(0));

    // Reset in the middle of a frame
    din = 4'b1011; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_mid_valid", 32'(sdo_valid), 32'(1));
    check("t4_mid_sdo",   32'(sdo),       32'(0));
    reset = 1'b1;
    #1;
    check("t4_rst_valid",  32'(sdo_valid),     32'(0));
    check("t4_rst_sdo",    32'(sdo),           32'(0));
    check("t4_rst_msdo",   32'(m_sdo),         32'(1));
    check("t4_rst_frames", 32'(frames_sent),   32'(0));
    check("t4_rst_mfr",    32'(m_frames_sent), 32'(0));
    check("t4_rst_cw",     32'(cw),            32'(0));
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0;
    @(negedge clk);
    check("t4_ready",  32'(din_ready),   32'(1));
    check("t4_valid",  32'(sdo_valid),   32'(0));
    check("t4_frames", 32'(frames_sent), 32'(0));

`ifdef ERR_INJECT_EN
    // Error injection: parity bit, data bit, out-of-range position
    din = 4'b1011; err_en = 1'b1; err_pos = 4'd5; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("t6_cw5",  32'(cw),         32'(14'h2DAD));
    check("t6_dec5", 32'(decode(cw)), 32'(4'b1011));
    run_frame("t6a", 14'h2DAD);
    err_pos = 4'd11; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("t6_cw11",  32'(cw),         32'(14'h258D));
    check("t6_dec11", 32'(decode(cw)), 32'(4'b1011));
    run_frame("t6b", 14'h258D);
    err_pos = 4'd14; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("t6_cw14", 32'(cw), 32'(14'h2D8D));
    run_frame("t6c", 14'h2D8D);
    err_en = 1'b0;
    exp_frames += 3;
    check("t6_frames", 32'(frames_sent), 32'(exp_frames));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/encoder_serial_tx.md
Name: encoder_serial_tx

Overview:
Transmit end of the (14,4) systematic linear block code link; feeds the existing combinational syndrome decoder. It accepts 4-bit data words over a valid/ready handshake and computes the 14-bit codeword. The codeword is serialised onto a one-bit line with frame strobes, and the parallel codeword is also exposed for loopback into the decoder.

Parameters:
LSB_FIRST, 1, 1: shift cw[0] first; 0: shift cw[13] first
IDLE_LEVEL, 0, value driven on sdo when no frame is active
CNT_W, 16, width of the sent-frame counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
din  input  4  data word d[3:0]
din_valid  input  1  din is valid
din_ready  output  1  block can accept din this cycle
cw  output  14  registered codeword of the frame in flight or last sent
sdo  output  1  serial codeword bit
sdo_valid  output  1  sdo carries a codeword bit
sof  output  1  high on the first bit of a frame
eof  output  1  high on the last bit of a frame
frames_sent  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W

Behaviour:
- Encoding is combinational on din and is latched into cw_reg when a word is accepted.
- The data bits map as cw[13:10] = d[3:0].
- Parity bits (XOR):
  - p0 = d0
  - p1 = d0^d1
  - p2 = d0^d2
  - p3 = d1^d2
  - p4 = d0^d1^d2
  - p5 = d0^d3
  - p6 = d1^d3
  - p7 = d0^d1^d3
  - p8 = d2^d3
  - p9 = d0^d2^d3
- Parity bits occupy cw[9:0] = p9..p0.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE, bit_cnt=0, cw=0, frames_sent=0.
  - sdo=IDLE_LEVEL; sdo_valid, sof, eof = 0.
  - The frame in progress is abandoned and not counted.
- FSM has two states, IDLE and SHIFT.
  - din_ready = (state==IDLE) || (state==SHIFT && bit_cnt==13).
  - Accept = din_valid && din_ready, sampled at the rising edge.
  - IDLE, accept: latch cw_reg, bit_cnt<=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: bit_cnt increments each cycle.
  - SHIFT at bit_cnt==13 with accept: load the new cw_reg, bit_cnt<=0, stay in SHIFT. This gives back-to-back frames with no gap.
  - SHIFT at bit_cnt==13 without accept: go to IDLE.
- Outputs are all driven from registers. In SHIFT:
  - sdo_valid=1.
  - sdo = cw_reg[bit_cnt] when LSB_FIRST=1, else cw_reg[13-bit_cnt].
  - sof = (bit_cnt==0); eof = (bit_cnt==13).
- Latency: a word accepted at edge k puts its first bit on sdo in the cycle after edge k. A frame lasts exactly 14 cycles; throughput is one word per 14 cycles.
- frames_sent increments on the edge that ends an eof cycle, and wraps to 0 after all-ones.
- cw holds its value after the frame ends until the next accept.
- din_valid while din_ready=0: the word is not accepted. The source must hold din stable; nothing is dropped or buffered.
- There is no X propagation; every register has a reset value.

Optional Feature:
ERR_INJECT_EN
- Defined:
  - Adds inputs err_en (1 bit) and err_pos (4 bits), both sampled on accept.
  - If err_en=1 and err_pos<=13, cw_reg[err_pos] is inverted at the latch. This affects both the cw and sdo outputs for that frame.
  - err_pos>=14 does nothing.
  - Purpose: exercising single-bit correction in the decoder.
- Undefined: the ports do not exist and codewords are always clean.

Test Plan:
1. Reset, then din=4'b1011 with din_valid pulsed one cycle:
   - cw=14'h2D8D.
   - sdo sequence (LSB first) 1,0,1,1,0,0,0,1,1,0,1,1,0,1.
   - sof on bit 0, eof on bit 13; frames_sent=1 afterwards.
2. Encode din=0000, 1111 and 0001 -> cw = 14'h0000, 14'h3E91, 14'h06B7.
   - Loop each cw into the decoder -> decoded d equals din.
3. din_valid held high with 0001 then 1111 -> second accept on the eof cycle.
   - sof of frame 2 is immediately after eof of frame 1 (no gap); frames_sent=2.
4. Assert reset at bit_cnt=6 of a frame:
   - sdo=IDLE_LEVEL and sdo_valid=0 immediately; frames_sent=0; din_ready=1 after release.
5. LSB_FIRST=0, din=1011 -> sdo sequence 1,0,1,1,0,1,1,0,0,0,1,1,0,1.
6. ERR_INJECT_EN, din=1011, err_en=1, err_pos=5:
   - cw=14'h2DAD; the decoder returns d=1011.
   - err_pos=14 -> cw=14'h2D8D.
